// File: rtl/dec_entry_accum_pkg.sv
// Shared definitions for the decimal operand entry accumulator.
package dec_entry_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int DIGIT_MAX = 9;
    localparam int RADIX     = 10;

    function automatic logic digit_legal(input logic [3:0] d);
        return d <= 4'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/dec_entry_accum_mac.sv
// Combinational mag*10+digit with a sign-dependent range check.
module dec_mac_check
    import dec_entry_accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mag,
    input  logic [3:0]       digit,
    input  logic             neg,
    output logic [WIDTH-1:0] prod,
    output logic             ok
);

    logic [WIDTH+3:0] prod_w;
    logic [WIDTH+3:0] limit_w;

    // Four extra bits hold any WIDTH-bit magnitude times ten plus a digit.
    always_comb begin
        prod_w  = (WIDTH+4)'(mag) * (WIDTH+4)'(RADIX) + (WIDTH+4)'(digit);
        limit_w = (WIDTH+4)'(1) << (WIDTH-1);
        if (!neg) begin
            limit_w = limit_w - (WIDTH+4)'(1);
        end
        prod = prod_w[WIDTH-1:0];
        ok   = (prod_w <= limit_w);
    end

endmodule

// File: rtl/dec_entry_accum.sv
// Decimal key entry to signed operand, with valid/ready hand-off of the committed value.
// Handshake: out_data is transferred on a rising clock edge where out_valid && out_ready;
// out_valid never drops and out_data never changes until that transfer happens.
module dec_entry_accum
    import dec_entry_accum_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             neg_toggle,
    input  logic             clear,
    input  logic             enter,
    output logic [WIDTH-1:0] value,
    output logic [1:0]       digit_count,
    output logic             overflow,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] MAG_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] od_q, od_d;

    logic [WIDTH-1:0] mac_prod;
    logic             mac_ok;
    logic             digit_ok;

    dec_mac_check #(.WIDTH(WIDTH)) u_mac (
        .mag   (mag_q),
        .digit (digit),
        .neg   (neg_q),
        .prod  (mac_prod),
        .ok    (mac_ok)
    );

    assign digit_ok = digit_valid && digit_legal(digit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    // Strobe priority: clear > enter > neg_toggle > digit.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    mag_d = '0;
                    neg_d = 1'b0;
                    cnt_d = '0;
                end else if (enter) begin
                    state_d = ST_IDLE;
                end else if (neg_toggle) begin
                    neg_d = ~neg_q;
                end else if (digit_ok) begin
                    mag_d   = WIDTH'(digit);
                    cnt_d   = 2'd1;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (clear) begin
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (enter) begin
                    od_d    = value;
                    ov_d    = 1'b1;
                    state_d = ST_HOLD;
                end else if (neg_toggle) begin
                    // +2^(WIDTH-1) is not representable, so flipping -2^(WIDTH-1) overflows.
                    if (neg_q && (mag_q == MAG_MIN_NEG)) begin
                        state_d = ST_ERROR;
                    end else begin
                        neg_d = ~neg_q;
                    end
                end else if (digit_ok && (cnt_q != 2'(MAX_DIGITS))) begin
                    if (mac_ok) begin
                        mag_d = mac_prod;
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_HOLD: begin
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (clear) begin
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign value       = neg_q ? (~mag_q + 1'b1) : mag_q;
    assign digit_count = cnt_q;
    assign overflow    = (state_q == ST_ERROR);
    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_dec_entry_accum.sv
// Self-checking bench for dec_entry_accum: scenario tasks plus a committed-operand scoreboard.
module tb_dec_entry_accum;
    import dec_entry_accum_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         digit_valid = 1'b0;
    logic [3:0]   digit = 4'd0;
    logic         neg_toggle = 1'b0;
    logic         clear = 1'b0;
    logic         enter = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] value;
    logic [1:0]   digit_count;
    logic         overflow;
    logic         out_valid;
    logic [W-1:0] out_data;
    state_t       state_dbg;

    int checks = 0;
    int passed = 0;
    logic [W-1:0] exp_q[$];

    dec_entry_accum #(.WIDTH(W), .MAX_DIGITS(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .neg_toggle  (neg_toggle),
        .clear       (clear),
        .enter       (enter),
        .value       (value),
        .digit_count (digit_count),
        .overflow    (overflow),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic idle_cycle();
        @(posedge clock); #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        @(posedge clock); #1;
        digit_valid = 1'b1;
        digit       = d;
        @(posedge clock); #1;
        digit_valid = 1'b0;
        digit       = $urandom_range(0, 15);
    endtask

    task automatic press_neg();
        @(posedge clock); #1; neg_toggle = 1'b1;
        @(posedge clock); #1; neg_toggle = 1'b0;
    endtask

    task automatic press_enter();
        @(posedge clock); #1; enter = 1'b1;
        @(posedge clock); #1; enter = 1'b0;
    endtask

    task automatic press_clear();
        @(posedge clock); #1; clear = 1'b1;
        @(posedge clock); #1; clear = 1'b0;
    endtask

    // Scoreboard: compare each transferred operand against the expected queue
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: out_data=%0h with empty expected queue", out_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL sb_data: got %0h expected %0h", out_data, e);
                else passed++;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({value, digit_count, overflow, out_valid, out_data} !== '0)
            $display("FAIL reset_outputs: got v=%0h c=%0d ov=%b vld=%b d=%0h expected all 0",
                     value, digit_count, overflow, out_valid, out_data);
        else passed++;
        checks++;
        if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
        else passed++;
        reset_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_commit_max();
        out_ready = 1'b1;
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd7);
        checks++;
        if (value !== 8'h7F || digit_count !== 2'd3)
            $display("FAIL max_entry: got v=%0h c=%0d expected 7f/3", value, digit_count);
        else passed++;
        exp_q.push_back(8'h7F);
        press_enter();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7F)
            $display("FAIL max_commit: got vld=%b d=%0h expected 1/7f", out_valid, out_data);
        else passed++;
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0 || value !== 8'h00 || state_dbg !== ST_IDLE)
            $display("FAIL max_release: got vld=%b v=%0h st=%0d expected 0/0/IDLE", out_valid, value, state_dbg);
        else passed++;
    endtask

    task automatic test_overflow();
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd8);
        checks++;
        if (overflow !== 1'b1 || value !== 8'd12 || digit_count !== 2'd2)
            $display("FAIL ovf_set: got ov=%b v=%0d c=%0d expected 1/12/2", overflow, value, digit_count);
        else passed++;
        press_enter();
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_enter_ignored: got vld=%b ov=%b expected 0/1", out_valid, overflow);
        else passed++;
        press_clear();
        checks++;
        if (overflow !== 1'b0 || value !== 8'h00 || state_dbg !== ST_IDLE)
            $display("FAIL ovf_clear: got ov=%b v=%0h st=%0d expected 0/0/IDLE", overflow, value, state_dbg);
        else passed++;
    endtask

    task automatic test_negative();
        out_ready = 1'b1;
        press_neg();
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd8);
        checks++;
        if (value !== 8'h80 || overflow !== 1'b0)
            $display("FAIL neg_min: got v=%0h ov=%b expected 80/0", value, overflow);
        else passed++;
        exp_q.push_back(8'h80);
        press_enter();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h80)
            $display("FAIL neg_commit: got vld=%b d=%0h expected 1/80", out_valid, out_data);
        else passed++;
        idle_cycle();
        press_neg();
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd8);
        press_neg();
        checks++;
        if (overflow !== 1'b1 || value !== 8'h80)
            $display("FAIL neg_flip_min: got ov=%b v=%0h expected 1/80", overflow, value);
        else passed++;
        press_clear();
        checks++;
        if (overflow !== 1'b0 || value !== 8'h00)
            $display("FAIL neg_clear: got ov=%b v=%0h expected 0/0", overflow, value);
        else passed++;
    endtask

    task automatic test_max_digits();
        press_digit(4'd5);
        press_digit(4'd5);
        press_digit(4'd5);
        checks++;
        if (overflow !== 1'b1 || value !== 8'd55)
            $display("FAIL digits_555: got ov=%b v=%0d expected 1/55", overflow, value);
        else passed++;
        press_clear();
        press_digit(4'd0);
        press_digit(4'd4);
        press_digit(4'hB);
        checks++;
        if (value !== 8'd4 || digit_count !== 2'd2)
            $display("FAIL digit_gt9: got v=%0d c=%0d expected 4/2", value, digit_count);
        else passed++;
        press_digit(4'd2);
        press_digit(4'd9);
        checks++;
        if (value !== 8'd42 || digit_count !== 2'd3 || overflow !== 1'b0)
            $display("FAIL digits_cap: got v=%0d c=%0d ov=%b expected 42/3/0", value, digit_count, overflow);
        else passed++;
        press_clear();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        press_digit(4'd9);
        press_digit(4'd9);
        exp_q.push_back(8'd99);
        press_enter();
        for (int i = 0; i < 5; i++) begin
            clear       = i[0];
            digit_valid = ~i[0];
            digit       = 4'd3;
            idle_cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd99 || state_dbg !== ST_HOLD)
                $display("FAIL hold_stable[%0d]: got vld=%b d=%0d st=%0d expected 1/99/HOLD",
                         i, out_valid, out_data, state_dbg);
            else passed++;
        end
        clear       = 1'b0;
        digit_valid = 1'b0;
        out_ready   = 1'b1;
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0 || state_dbg !== ST_IDLE)
            $display("FAIL hold_accept: got vld=%b st=%0d expected 0/IDLE", out_valid, state_dbg);
        else passed++;
    endtask

    task automatic test_async_reset();
        press_digit(4'd1);
        press_digit(4'd2);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (value !== 8'h00 || digit_count !== 2'd0 || state_dbg !== ST_IDLE)
            $display("FAIL areset_entry: got v=%0h c=%0d st=%0d expected 0/0/IDLE", value, digit_count, state_dbg);
        else passed++;
        idle_cycle();
        reset_n   = 1'b1;
        out_ready = 1'b0;
        press_digit(4'd3);
        press_enter();
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || value !== 8'h00)
            $display("FAIL areset_hold: got vld=%b d=%0h v=%0h expected 0/0/0", out_valid, out_data, value);
        else passed++;
        idle_cycle();
        reset_n = 1'b1;
        press_digit(4'd4);
        @(posedge clock); #1;
        clear = 1'b1;
        enter = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        enter = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || value !== 8'h00 || state_dbg !== ST_IDLE)
            $display("FAIL clear_beats_enter: got vld=%b v=%0h st=%0d expected 0/0/IDLE",
                     out_valid, value, state_dbg);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_commit_max();
        test_overflow();
        test_negative();
        test_max_digits();
        test_back_pressure();
        test_async_reset();
        repeat (2) idle_cycle();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
